// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, iterative shift-add multiply and
// restoring divide, valid/ready handshake on both sides.
module alu_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             err
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [3:0] OpAdd = 4'd0, OpSub = 4'd1, OpAnd = 4'd2, OpOr = 4'd3;
  localparam logic [3:0] OpXor = 4'd4, OpShl = 4'd5, OpShr = 4'd6, OpCmp = 4'd7;
  localparam logic [3:0] OpMul = 4'd8, OpDivu = 4'd9, OpRemu = 4'd10;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             z_q, z_d, c_q, c_d, n_q, n_d, err_q, err_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] qr_res;
  logic             qr_c, qr_err, iterative;
  logic [WIDTH-1:0] mul_acc, fin_res;
  logic [WIDTH:0]   r_sh, r_sub;
  logic             ge;

  // Single-cycle result path, evaluated on the live inputs at accept.
  always_comb begin
    sum    = {1'b0, in_a} + {1'b0, in_b};
    qr_res = '0;
    qr_c   = 1'b0;
    qr_err = 1'b0;
    unique case (select)
      OpAdd: {qr_c, qr_res} = sum;
      OpSub: begin
        qr_res = in_a - in_b;
        qr_c   = in_a < in_b;
      end
      OpAnd: qr_res = in_a & in_b;
      OpOr:  qr_res = in_a | in_b;
      OpXor: qr_res = in_a ^ in_b;
      OpShl: qr_res = in_a << in_b;
      OpShr: qr_res = in_a >> in_b;
      OpCmp: qr_res = (in_a > in_b) ? WIDTH'(1) : (in_a < in_b) ? WIDTH'(2) : '0;
      OpMul: qr_res = '0;
      OpDivu: begin
        qr_res = '1;
        qr_err = 1'b1;
      end
      OpRemu: begin
        qr_res = in_a;
        qr_err = 1'b1;
      end
      default: qr_err = 1'b1;
    endcase
    iterative = (select == OpMul) ||
                (((select == OpDivu) || (select == OpRemu)) && (in_b != '0));
  end

  // One iteration step: shift-add for multiply, restoring step for divide.
  always_comb begin
    mul_acc = acc_q[WIDTH-1:0] + (b_q[0] ? a_q : '0);
    r_sh    = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
    ge      = r_sh >= {1'b0, b_q};
    r_sub   = r_sh - {1'b0, b_q};
    if (op_q == OpMul) begin
      fin_res = mul_acc;
    end else if (op_q == OpDivu) begin
      fin_res = {a_q[WIDTH-2:0], ge};
    end else begin
      fin_res = ge ? r_sub[WIDTH-1:0] : r_sh[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    z_d     = z_q;
    c_d     = c_q;
    n_d     = n_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d = select;
          if (iterative) begin
            state_d = StBusy;
            a_d     = in_a;
            b_d     = in_b;
            acc_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
          end else begin
            state_d = StDone;
            res_d   = qr_res;
            c_d     = qr_c;
            err_d   = qr_err;
            z_d     = qr_res == '0;
            n_d     = qr_res[WIDTH-1];
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (op_q == OpMul) begin
          acc_d = {1'b0, mul_acc};
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
        end else begin
          a_d   = {a_q[WIDTH-2:0], ge};
          acc_d = ge ? r_sub : r_sh;
        end
        if (cnt_q == CNT_W'(1)) begin
          state_d = StDone;
          res_d   = fin_res;
          c_d     = 1'b0;
          err_d   = 1'b0;
          z_d     = fin_res == '0;
          n_d     = fin_res[WIDTH-1];
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      z_q     <= z_d;
      c_q     <= c_d;
      n_q     <= n_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = state_q == StIdle;
  assign out_valid = state_q == StDone;
  assign alu_out   = res_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign flag_n    = n_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=16): latency, results, flags, backpressure, reset abort.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [3:0]  select = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] alu_out;
  logic        flag_z, flag_c, flag_n, err;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .select    (select),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_n    (flag_n),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for the result (bounded), check it, then let it drain.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] op, input logic [15:0] exp_res, input logic exp_c,
                        input logic exp_err, input int exp_lat);
    int   lat;
    logic rdy_bad;
    in_a = a;
    in_b = b;
    select = op;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a = 16'($urandom);
    in_b = 16'($urandom);
    select = 4'($urandom);
    lat = 1;
    rdy_bad = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_bad = 1'b1;
      tick();
      lat++;
    end
    chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".res"}, alu_out, exp_res);
    chk({tag, ".z"}, flag_z, exp_res == 16'h0);
    chk({tag, ".n"}, flag_n, exp_res[15]);
    chk({tag, ".c"}, flag_c, exp_c);
    chk({tag, ".err"}, err, exp_err);
    chk({tag, ".busy_rdy"}, rdy_bad, 1'b0);
    chk({tag, ".done_rdy"}, in_ready, 1'b0);
    tick();
    chk({tag, ".drain_v"}, out_valid, 1'b0);
    chk({tag, ".drain_rdy"}, in_ready, 1'b1);
  endtask

  initial begin
    logic seen_valid;

    repeat (2) tick();
    chk("rst.in_ready", in_ready, 1'b1);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.alu_out", alu_out, 16'h0);
    chk("rst.flags", {flag_z, flag_c, flag_n, err}, 4'b0000);
    rst_n = 1'b1;
    tick();

    run_op("add_wrap", 16'hFFFF, 16'h0001, 4'd0, 16'h0000, 1'b1, 1'b0, 1);
    run_op("sub_neg",  16'h0003, 16'h0005, 4'd1, 16'hFFFE, 1'b1, 1'b0, 1);
    run_op("and",      16'hF0F0, 16'h3C3C, 4'd2, 16'h3030, 1'b0, 1'b0, 1);
    run_op("or",       16'hF0F0, 16'h3C3C, 4'd3, 16'hFCFC, 1'b0, 1'b0, 1);
    run_op("xor",      16'hF0F0, 16'h3C3C, 4'd4, 16'hCCCC, 1'b0, 1'b0, 1);
    run_op("shl16",    16'h0001, 16'd16,   4'd5, 16'h0000, 1'b0, 1'b0, 1);
    run_op("shl4",     16'h0001, 16'd4,    4'd5, 16'h0010, 1'b0, 1'b0, 1);
    run_op("shr15",    16'h8000, 16'd15,   4'd6, 16'h0001, 1'b0, 1'b0, 1);
    run_op("cmp_gt",   16'd5,    16'd3,    4'd7, 16'd1,    1'b0, 1'b0, 1);
    run_op("cmp_lt",   16'd3,    16'd5,    4'd7, 16'd2,    1'b0, 1'b0, 1);
    run_op("cmp_eq",   16'd7,    16'd7,    4'd7, 16'd0,    1'b0, 1'b0, 1);
    run_op("mul",      16'h0123, 16'h0010, 4'd8, 16'h1230, 1'b0, 1'b0, 17);
    run_op("mul_max",  16'hFFFF, 16'hFFFF, 4'd8, 16'h0001, 1'b0, 1'b0, 17);
    run_op("divu",     16'd100,  16'd7,    4'd9, 16'd14,   1'b0, 1'b0, 17);
    run_op("remu",     16'd100,  16'd7,    4'd10, 16'd2,   1'b0, 1'b0, 17);
    run_op("divu_max", 16'hFFFF, 16'h0001, 4'd9, 16'hFFFF, 1'b0, 1'b0, 17);
    run_op("divu_z",   16'd5,    16'd0,    4'd9, 16'hFFFF, 1'b0, 1'b1, 1);
    run_op("remu_z",   16'd5,    16'd0,    4'd10, 16'd5,   1'b0, 1'b1, 1);
    run_op("resv",     16'h1234, 16'h5678, 4'd11, 16'h0,   1'b0, 1'b1, 1);

    // Backpressure: result must hold while a competing request is presented.
    in_a = 16'd2;
    in_b = 16'd3;
    select = 4'd0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    in_a = 16'd9;
    in_b = 16'd9;
    select = 4'd1;
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid", out_valid, 1'b1);
      chk("bp.res", alu_out, 16'd5);
      chk("bp.rdy", in_ready, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp.res_end", alu_out, 16'd5);
    tick();
    chk("bp.rel_v", out_valid, 1'b0);
    chk("bp.rel_rdy", in_ready, 1'b1);

    // Reset in BUSY cycle 8 of a multiply: no result may ever appear.
    in_a = 16'h0123;
    in_b = 16'h0010;
    select = 4'd8;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    chk("abort.busy", in_ready, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort.v", out_valid, 1'b0);
    chk("abort.res", alu_out, 16'h0);
    chk("abort.rdy", in_ready, 1'b1);
    seen_valid = 1'b0;
    repeat (20) begin
      tick();
      if (out_valid) seen_valid = 1'b1;
    end
    chk("abort.no_result", seen_valid, 1'b0);
    run_op("add_post", 16'h1234, 16'h0001, 4'd0, 16'h1235, 1'b0, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
